// File: rtl/spi_reg_map.sv
// spi_reg_map: register file sitting behind an SPI slave front end.
// A transaction opens with an addr_valid rising edge. A read loads read_data
// from the map on that edge. A write waits for a wr_data_valid rising edge and
// then spends one cycle in COMMIT, during which wr_strobe is high. All
// registers, including the edge-detect copies, are updated by one clocked block
// from the *_d values computed in a single combinational block.
module spi_reg_map #(
    parameter int         ADDR_W  = 7,
    parameter int         DATA_W  = 8,
    parameter logic [7:0] CHIP_ID = 8'hA5,
    parameter logic [7:0] VERSION = 8'h10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_start_flag,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              addr_valid,
    input  logic              rw_out,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_valid,
    output logic [DATA_W-1:0] read_data,
    output logic              read_en,
    input  logic [7:0]        status_in,
    input  logic [7:0]        irq_in,
    output logic [7:0]        ctrl_out,
    output logic [127:0]      gp_regs,
    output logic              irq,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr
);

    typedef enum logic [1:0] {IDLE, READ, WR_WAIT, COMMIT} state_t;

    localparam logic [ADDR_W-1:0] A_CHIP  = ADDR_W'('h00);
    localparam logic [ADDR_W-1:0] A_VER   = ADDR_W'('h01);
    localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'('h02);
    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'('h03);
    localparam logic [ADDR_W-1:0] A_FLAGS = ADDR_W'('h04);
    localparam logic [ADDR_W-1:0] A_MASK  = ADDR_W'('h05);
    localparam logic [ADDR_W-1:0] A_ERR   = ADDR_W'('h06);
    localparam logic [ADDR_W-1:0] A_GP_LO = ADDR_W'('h10);
    localparam logic [ADDR_W-1:0] A_GP_HI = ADDR_W'('h1F);

    // Saturating increment for the error counter
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Full-width range test so that no upper address bits alias into GP space
    function automatic logic is_gp(input logic [ADDR_W-1:0] a);
        return (a >= A_GP_LO) && (a <= A_GP_HI);
    endfunction

    // Writes anywhere else (RO or reserved) count as errors
    function automatic logic is_writable(input logic [ADDR_W-1:0] a);
        return (a == A_CTRL) || (a == A_FLAGS) || (a == A_MASK) ||
               (a == A_ERR) || is_gp(a);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                av_q, av_d;
    logic                wdv_q, wdv_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;
    logic                read_en_q, read_en_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          ctrl_q, ctrl_d;
    logic [7:0]          flags_q, flags_d;
    logic [7:0]          mask_q, mask_d;
    logic [7:0]          err_q, err_d;
    logic [127:0]        gp_q, gp_d;
    logic                irq_q, irq_d;

    logic                av_rise;
    logic                wdv_rise;
    logic                do_commit;
    logic [7:0]          flag_clr;
    logic [7:0]          wbyte;
    logic [7:0]          rd_byte;

    assign av_rise  = addr_valid & ~av_q;
    assign wdv_rise = wr_data_valid & ~wdv_q;
    assign wbyte    = wr_data[7:0];

    // Read mux on the live address; only sampled on the launch edge of a read
    always_comb begin
        rd_byte = 8'h00;
        if (reg_addr == A_CHIP)       rd_byte = CHIP_ID;
        else if (reg_addr == A_VER)   rd_byte = VERSION;
        else if (reg_addr == A_STAT)  rd_byte = status_in;
        else if (reg_addr == A_CTRL)  rd_byte = ctrl_q;
        else if (reg_addr == A_FLAGS) rd_byte = flags_q;
        else if (reg_addr == A_MASK)  rd_byte = mask_q;
        else if (reg_addr == A_ERR)   rd_byte = err_q;
        else if (is_gp(reg_addr))     rd_byte = gp_q[{reg_addr[3:0], 3'b000} +: 8];
    end

    // Next-state logic for the transaction FSM and every register it controls
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        av_d        = addr_valid;
        wdv_d       = wr_data_valid;
        read_data_d = read_data_q;
        read_en_d   = read_en_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        ctrl_d      = ctrl_q;
        mask_d      = mask_q;
        err_d       = err_q;
        gp_d        = gp_q;
        do_commit   = 1'b0;
        flag_clr    = 8'h00;

        case (state_q)
            IDLE: begin
                if (!spi_start_flag && av_rise) begin
                    addr_d = reg_addr;
                    if (rw_out) begin
                        state_d     = READ;
                        read_data_d = DATA_W'(rd_byte);
                        read_en_d   = 1'b1;
                    end else begin
                        state_d = WR_WAIT;
                    end
                end
            end
            READ: begin
                if (spi_start_flag || !addr_valid) begin
                    state_d     = IDLE;
                    read_en_d   = 1'b0;
                    read_data_d = '0;
                end
            end
            WR_WAIT: begin
                if (spi_start_flag || !addr_valid) begin
                    state_d = IDLE;
                end else if (wdv_rise) begin
                    state_d     = COMMIT;
                    do_commit   = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = addr_q;
                end
            end
            COMMIT: begin
                // The register update happened on the edge entering COMMIT;
                // this cycle only presents wr_strobe.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (do_commit) begin
            if (addr_q == A_CTRL)       ctrl_d   = wbyte;
            else if (addr_q == A_FLAGS) flag_clr = wbyte;
            else if (addr_q == A_MASK)  mask_d   = wbyte;
            else if (addr_q == A_ERR)   err_d    = 8'h00;
            else if (is_gp(addr_q))     gp_d[{addr_q[3:0], 3'b000} +: 8] = wbyte;
            if (!is_writable(addr_q))   err_d    = sat_inc(err_q);
        end

        // Set wins over clear on the same bit
        flags_d = (flags_q & ~flag_clr) | irq_in;
        irq_d   = |(flags_q & mask_q);
    end

    // All state; edge-detect copies reset high so a level already present
    // at reset release is not mistaken for a fresh rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            av_q        <= 1'b1;
            wdv_q       <= 1'b1;
            read_data_q <= '0;
            read_en_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            ctrl_q      <= 8'h00;
            flags_q     <= 8'h00;
            mask_q      <= 8'h00;
            err_q       <= 8'h00;
            gp_q        <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            av_q        <= av_d;
            wdv_q       <= wdv_d;
            read_data_q <= read_data_d;
            read_en_q   <= read_en_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            ctrl_q      <= ctrl_d;
            flags_q     <= flags_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            gp_q        <= gp_d;
            irq_q       <= irq_d;
        end
    end

    assign read_data = read_data_q;
    assign read_en   = read_en_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign ctrl_out  = ctrl_q;
    assign gp_regs   = gp_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_spi_reg_map.sv
// tb_spi_reg_map: directed and randomized transactions against a register-level
// model of the map (arrays and plain arithmetic).
module tb_spi_reg_map;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              spi_start_flag;
    logic [ADDR_W-1:0] reg_addr;
    logic              addr_valid;
    logic              rw_out;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_valid;
    logic [DATA_W-1:0] read_data;
    logic              read_en;
    logic [7:0]        status_in;
    logic [7:0]        irq_in;
    logic [7:0]        ctrl_out;
    logic [127:0]      gp_regs;
    logic              irq;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;

    always #5 clk = ~clk;

    spi_reg_map #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHIP_ID(8'hA5), .VERSION(8'h10)) dut (
        .clk(clk), .reset_n(reset_n), .spi_start_flag(spi_start_flag),
        .reg_addr(reg_addr), .addr_valid(addr_valid), .rw_out(rw_out),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .read_data(read_data), .read_en(read_en), .status_in(status_in),
        .irq_in(irq_in), .ctrl_out(ctrl_out), .gp_regs(gp_regs), .irq(irq),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_ctrl, m_flags, m_mask, m_err;
    logic [7:0] m_gp [16];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_flags = 0; m_mask = 0; m_err = 0;
        for (int i = 0; i < 16; i++) m_gp[i] = 8'h00;
    endtask

    function automatic logic [127:0] model_gp_vec();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_gp[i];
        return v;
    endfunction

    function automatic logic [7:0] model_read(input int a, input logic [7:0] st);
        if (a == 0)                return 8'hA5;
        if (a == 1)                return 8'h10;
        if (a == 2)                return st;
        if (a == 3)                return m_ctrl;
        if (a == 4)                return m_flags;
        if (a == 5)                return m_mask;
        if (a == 6)                return m_err;
        if (a >= 16 && a <= 31)    return m_gp[a-16];
        return 8'h00;
    endfunction

    task automatic model_write(input int a, input logic [7:0] d, input logic [7:0] pulse);
        if (a == 3)                  m_ctrl  = d;
        else if (a == 4)             m_flags = m_flags & ~d;
        else if (a == 5)             m_mask  = d;
        else if (a == 6)             m_err   = 8'h00;
        else if (a >= 16 && a <= 31) m_gp[a-16] = d;
        else if (m_err != 8'hFF)     m_err   = m_err + 8'd1;
        m_flags = m_flags | pulse;
    endtask

    // Full read transaction; status_in is flipped after launch to show it was sampled
    task automatic read_txn(input logic [6:0] a, input string tag);
        logic [7:0] exp;
        @(negedge clk); spi_start_flag = 1'b1;
        @(negedge clk); spi_start_flag = 1'b0;
        rw_out = 1'b1; reg_addr = a; addr_valid = 1'b1;
        exp = model_read(int'(a), status_in);
        @(negedge clk);
        chk({tag, "_en"}, read_en, 1);
        chk({tag, "_data"}, read_data, exp);
        status_in = ~status_in;
        @(negedge clk);
        chk({tag, "_hold_en"}, read_en, 1);
        chk({tag, "_hold_data"}, read_data, exp);
        addr_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_end_en"}, read_en, 0);
        chk({tag, "_end_data"}, read_data, 0);
    endtask

    // Full write transaction; pulse is driven on irq_in in the commit cycle
    task automatic write_txn(input logic [6:0] a, input logic [7:0] d,
                             input logic [7:0] pulse, input string tag);
        logic irq_old;
        @(negedge clk); spi_start_flag = 1'b1;
        @(negedge clk); spi_start_flag = 1'b0;
        rw_out = 1'b0; reg_addr = a; addr_valid = 1'b1;
        @(negedge clk);
        wr_data = d; wr_data_valid = 1'b1; irq_in = pulse;
        irq_old = |(m_flags & m_mask);
        model_write(int'(a), d, pulse);
        @(negedge clk); irq_in = 8'h00;
        chk({tag, "_strobe"}, wr_strobe, 1);
        chk({tag, "_wr_addr"}, wr_addr, a);
        chk({tag, "_irq_lag"}, irq, irq_old);
        @(negedge clk);
        chk({tag, "_strobe_once"}, wr_strobe, 0);
        chk({tag, "_irq"}, irq, |(m_flags & m_mask));
        chk({tag, "_ctrl"}, ctrl_out, m_ctrl);
        chk({tag, "_gp"}, gp_regs, model_gp_vec());
        wr_data_valid = 1'b0; addr_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b1; spi_start_flag = 0; reg_addr = '0; addr_valid = 0;
        rw_out = 0; wr_data = '0; wr_data_valid = 0; status_in = 8'h5A; irq_in = 8'h00;
        model_reset();
        #2 reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_read_en", read_en, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_ctrl", ctrl_out, 0);
        chk("rst_gp", gp_regs, 0);
        chk("rst_irq", irq, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Identification and status reads
        read_txn(7'h00, "rd_chip");
        read_txn(7'h01, "rd_ver");
        status_in = 8'hC3;
        read_txn(7'h02, "rd_status");

        // Write then read a GP register
        write_txn(7'h13, 8'h3C, 8'h00, "wr_gp13");
        chk("gp13_bits", gp_regs[31:24], 8'h3C);
        read_txn(7'h13, "rd_gp13");

        // Reserved and aliasing addresses
        read_txn(7'h40, "rd_rsv40");
        read_txn(7'h07, "rd_rsv07");
        read_txn(7'h53, "rd_alias53");
        write_txn(7'h50, 8'h77, 8'h00, "wr_alias50");
        read_txn(7'h06, "rd_err_alias");

        // Interrupt flags and mask
        @(negedge clk); irq_in = 8'h05; m_flags = m_flags | 8'h05;
        @(negedge clk); irq_in = 8'h00;
        write_txn(7'h05, 8'h04, 8'h00, "wr_mask");
        chk("irq_set", irq, 1);
        read_txn(7'h04, "rd_flags05");
        write_txn(7'h04, 8'h04, 8'h04, "wr_flags_setwins");
        read_txn(7'h04, "rd_flags_setwins");
        write_txn(7'h04, 8'h04, 8'h00, "wr_flags_clr");
        chk("irq_clr", irq, 0);
        read_txn(7'h04, "rd_flags01");
        @(negedge clk); irq_in = 8'h04; m_flags = m_flags | 8'h04;
        @(negedge clk); irq_in = 8'h00;
        chk("irq_pulse_lag", irq, 0);
        @(negedge clk);
        chk("irq_pulse_set", irq, 1);
        write_txn(7'h04, 8'h04, 8'h00, "wr_flags_clr2");

        // Randomized traffic over the whole address space
        for (int i = 0; i < 40; i++) begin
            logic [6:0] a;
            logic [7:0] d;
            case ($urandom_range(0, 3))
                0:       a = 7'h10 + 7'($urandom_range(0, 15));
                1:       a = 7'($urandom_range(0, 7));
                default: a = 7'($urandom);
            endcase
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) write_txn(a, d, 8'h00, "rnd_wr");
            else begin
                status_in = 8'($urandom);
                read_txn(a, "rnd_rd");
            end
        end

        // Error counter saturation and clear
        write_txn(7'h06, 8'h00, 8'h00, "err_clr0");
        for (int i = 0; i < 300; i++)
            write_txn((i % 2 == 0) ? 7'h00 : 7'h40, 8'($urandom), 8'h00, "err_wr");
        read_txn(7'h00, "rd_chip_after");
        read_txn(7'h06, "rd_err_sat");
        write_txn(7'h06, 8'h55, 8'h00, "err_clr");
        read_txn(7'h06, "rd_err_zero");

        // Abort by spi_start_flag while waiting for data
        @(negedge clk); spi_start_flag = 1'b1;
        @(negedge clk); spi_start_flag = 1'b0; rw_out = 1'b0; reg_addr = 7'h11; addr_valid = 1'b1;
        @(negedge clk); spi_start_flag = 1'b1;
        @(negedge clk); spi_start_flag = 1'b0; wr_data = 8'hEE; wr_data_valid = 1'b1;
        @(negedge clk); chk("abort_start_strobe0", wr_strobe, 0);
        @(negedge clk); chk("abort_start_strobe1", wr_strobe, 0);
        chk("abort_start_gp", gp_regs, model_gp_vec());
        wr_data_valid = 1'b0; addr_valid = 1'b0;

        // Abort by addr_valid falling before the data arrives
        @(negedge clk); rw_out = 1'b0; reg_addr = 7'h12; addr_valid = 1'b1;
        @(negedge clk); addr_valid = 1'b0;
        @(negedge clk); wr_data = 8'hDD; wr_data_valid = 1'b1;
        @(negedge clk); chk("abort_fall_strobe0", wr_strobe, 0);
        @(negedge clk); chk("abort_fall_strobe1", wr_strobe, 0);
        chk("abort_fall_gp", gp_regs, model_gp_vec());
        wr_data_valid = 1'b0;
        read_txn(7'h06, "rd_err_abort");
        read_txn(7'h12, "rd_gp12_abort");

        // Reset in the middle of a read
        write_txn(7'h03, 8'h9B, 8'h00, "wr_ctrl_pre");
        write_txn(7'h1F, 8'hA7, 8'h00, "wr_gp1f_pre");
        @(negedge clk); irq_in = 8'h01; m_flags = m_flags | 8'h01;
        @(negedge clk); irq_in = 8'h00;
        write_txn(7'h05, 8'h01, 8'h00, "wr_mask_pre");
        @(negedge clk); spi_start_flag = 1'b1;
        @(negedge clk); spi_start_flag = 1'b0; rw_out = 1'b1; reg_addr = 7'h01; addr_valid = 1'b1;
        @(negedge clk);
        chk("mid_rd_en", read_en, 1);
        chk("mid_rd_irq", irq, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_read_en", read_en, 0);
        chk("arst_read_data", read_data, 0);
        chk("arst_wr_strobe", wr_strobe, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_ctrl", ctrl_out, 0);
        chk("arst_gp", gp_regs, 0);
        chk("arst_irq", irq, 0);
        model_reset();
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); chk("post_rst_idle0", read_en, 0);
        @(negedge clk); chk("post_rst_idle1", read_en, 0);
        addr_valid = 1'b0;
        @(negedge clk);
        read_txn(7'h05, "rd_mask_post");
        read_txn(7'h06, "rd_err_post");
        read_txn(7'h01, "rd_ver_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_map.md
SPI_REG_MAP -- requirements
Module: spi_reg_map

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 7, register address width; DATA_W, default 8, register data width; CHIP_ID, default 8'hA5, value of register 0x00; VERSION, default 8'h10, value of register 0x01.
REQ-002 clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset; there SHALL be only this one clock and this one reset.
REQ-004 spi_start_flag  input  1  one-cycle pulse at chip-select assertion; aborts any transaction in progress.
REQ-005 reg_addr  input  ADDR_W  register address from the SPI slave; valid only while addr_valid=1.
REQ-006 addr_valid  input  1  level; rises once per transaction when the address is complete; falls at transaction end.
REQ-007 rw_out  input  1  1=read transaction, 0=write; stable before addr_valid rises.
REQ-008 wr_data  input  DATA_W  write payload; valid while wr_data_valid=1.
REQ-009 wr_data_valid  input  1  level; rises once after the last payload bit.
REQ-010 read_data  output  DATA_W  registered read value returned to the SPI slave.
REQ-011 read_en  output  1  level; high while read_data is valid for the current read.
REQ-012 status_in  input  8  live status; read through register 0x02.
REQ-013 irq_in  input  8  per-bit one-cycle event pulses.
REQ-014 ctrl_out  output  8  CONTROL register contents.
REQ-015 gp_regs  output  128  general-purpose registers 0x10..0x1F concatenated; register 0x10 occupies bits [7:0].
REQ-016 irq  output  1  registered OR of (IRQ_FLAGS & IRQ_MASK).
REQ-017 wr_strobe / wr_addr  output  1 / ADDR_W  one-cycle commit pulse and the committed address.

Function
REQ-018 Register map SHALL be:
- 0x00 CHIP_ID, RO
- 0x01 VERSION, RO
- 0x02 STATUS, RO; returns status_in sampled at read launch
- 0x03 CONTROL, RW
- 0x04 IRQ_FLAGS, W1C
- 0x05 IRQ_MASK, RW
- 0x06 ERR_CNT, RO; any write clears it
- 0x10..0x1F GP, RW
- all other addresses reserved: read 8'h00, writes ignored.
REQ-019 FSM states SHALL be IDLE, READ, WR_WAIT and COMMIT; the edge detectors on addr_valid and wr_data_valid SHALL use one registered copy of each signal.
REQ-020 IDLE -> READ on an addr_valid rising edge with rw_out=1: latch the address, load read_data from the map, and assert read_en on the same clock edge, i.e. read_en is high 1 cycle after the addr_valid edge is registered.
REQ-021 In READ, read_data and read_en SHALL hold; READ -> IDLE when addr_valid=0 or spi_start_flag=1, with read_en=0 and read_data=0 on the next cycle.
REQ-022 IDLE -> WR_WAIT on an addr_valid rising edge with rw_out=0: latch the address.
REQ-023 WR_WAIT -> COMMIT on a wr_data_valid rising edge.
REQ-024 WR_WAIT -> IDLE with no write when addr_valid falls first.
REQ-025 COMMIT SHALL last exactly 1 cycle: update the target register with wr_data, pulse wr_strobe=1 with wr_addr=latched address, then go to IDLE; exactly one commit per transaction.
REQ-026 spi_start_flag SHALL force IDLE from any state; no commit occurs in that cycle.
REQ-027 Writes to a RO or reserved address SHALL still pulse wr_strobe, leave all registers unchanged, and increment ERR_CNT.
REQ-028 ERR_CNT SHALL saturate at 8'hFF.
REQ-029 A write to 0x06 SHALL clear ERR_CNT to 0 and SHALL NOT count as an error.
REQ-030 IRQ_FLAGS: flag[i] SHALL set on irq_in[i]=1; a write clears the bits where wr_data=1; a simultaneous set and clear on the same bit SHALL leave the bit set.
REQ-031 Reading IRQ_FLAGS SHALL have no side effect.
REQ-032 irq SHALL update 1 cycle after any change to IRQ_FLAGS or IRQ_MASK.
REQ-033 Address comparison SHALL use all ADDR_W bits; there SHALL be no aliasing.

Reset
REQ-034 On reset_n=0 the block SHALL immediately (asynchronously) set: FSM=IDLE; read_data=0; read_en=0; wr_strobe=0; wr_addr=0; ctrl_out=0; IRQ_FLAGS=0; IRQ_MASK=0; ERR_CNT=0; gp_regs=0; irq=0.
REQ-035 Reset asserted mid-transaction SHALL discard that transaction; after release, the block SHALL wait for a fresh addr_valid rising edge before acting.

Verification
REQ-036 Read 0x00 (rw_out=1, addr_valid rises) -> read_en=1 one cycle after the registered edge, read_data=8'hA5 held until addr_valid falls, then read_data=0 and read_en=0.
REQ-037 Write 8'h3C to 0x13, then read 0x13 -> one wr_strobe with wr_addr=0x13; gp_regs[31:24]=8'h3C; read returns 8'h3C.
REQ-038 irq_in=8'h05 pulse, IRQ_MASK=8'h04 -> irq=1; then write 8'h04 to 0x04 in the same cycle as an irq_in[2] pulse -> flag[2] stays 1; a later write of 8'h04 -> IRQ_FLAGS=8'h01, irq=0.
REQ-039 Write to 0x00 and to 0x40, 300 times in total -> CHIP_ID unchanged, ERR_CNT=8'hFF; then write to 0x06 -> ERR_CNT=0.
REQ-040 Write transaction with spi_start_flag pulsed while in WR_WAIT, and separately with addr_valid falling before wr_data_valid -> no wr_strobe, no register changes.
REQ-041 reset_n low for 1 cycle while in READ -> read_en=0 immediately; all outputs at their reset values.
